// File: rtl/rf_init_sequencer_if.sv
// rf_init_sequencer_if: data memory read port and register file write port driven by the init sequencer
interface rf_init_sequencer_if #(parameter int DATA_W = 8, MADDR_W = 8, IW = 3);
  logic mem_req, mem_valid, rf_write, rf_dest;
  logic [MADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata, rf_writeData;
  logic [IW-1:0] rf_src1;
  modport master(output mem_req, mem_addr, rf_write, rf_dest, rf_src1, rf_writeData, input mem_rdata, mem_valid);
  modport slave(input mem_req, mem_addr, rf_write, rf_dest, rf_src1, rf_writeData, output mem_rdata, mem_valid);
endinterface

// File: rtl/rf_init_sequencer.sv
// rf_init_sequencer: preloads the register file from a memory image, or clears it, while stalling the core
module rf_init_sequencer #(
  parameter int NUM_REGS = 8,
  parameter int DATA_W = 8,
  parameter int MADDR_W = 8,
  parameter int TIMEOUT = 15,
  parameter logic [6:0] CLEAR_CODE = 7'h7F
) (
  input  logic clock,
  input  logic reset_n,
  input  logic start,
  input  logic [6:0] start_address,
  rf_init_sequencer_if.master bus,
  output logic core_stall,
  output logic busy,
  output logic done,
  output logic error
);
  localparam int IW = $clog2(NUM_REGS);
  localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);
  typedef enum logic [2:0] {IDLE, FETCH, WRITE, CLEAR, DONE} state_t;
  state_t state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [6:0] base, base_n;
  logic [DATA_W-1:0] data_q, data_n;
  logic [3:0] tmo, tmo_n;
  logic clr_wr, abort, wr_n;
  always_comb begin
    state_n = state;
    idx_n = idx;
    base_n = base;
    data_n = data_q;
    tmo_n = tmo;
    clr_wr = 1'b0;
    abort = 1'b0;
    case (state)
      IDLE: if (start) begin
        base_n = start_address;
        idx_n = '0;
        tmo_n = '0;
        state_n = start_address == CLEAR_CODE ? CLEAR : FETCH;
      end
      FETCH: if (bus.mem_valid) begin
        data_n = bus.mem_rdata;
        tmo_n = '0;
        state_n = WRITE;
      end else if (tmo == 4'(TIMEOUT - 1)) begin
        abort = 1'b1;
        tmo_n = '0;
        state_n = DONE;
      end else tmo_n = tmo + 1'b1;
      WRITE: begin
        state_n = idx == LAST ? DONE : FETCH;
        idx_n = idx == LAST ? idx : idx + 1'b1;
      end
      // clear writes are presented one cycle after being issued; leave once the last one is on the port
      CLEAR: if (bus.rf_write && bus.rf_src1 == LAST) state_n = DONE;
      else begin
        clr_wr = 1'b1;
        idx_n = idx == LAST ? idx : idx + 1'b1;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign wr_n = state_n == WRITE || clr_wr;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      idx <= '0;
      base <= '0;
      data_q <= '0;
      tmo <= '0;
      bus.mem_req <= 1'b0;
      bus.mem_addr <= '0;
      bus.rf_write <= 1'b0;
      bus.rf_src1 <= '0;
      bus.rf_writeData <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      base <= base_n;
      data_q <= data_n;
      tmo <= tmo_n;
      bus.mem_req <= state_n == FETCH;
      bus.mem_addr <= state_n == FETCH ? MADDR_W'({1'b0, base_n}) + MADDR_W'(idx_n) : '0;
      bus.rf_write <= wr_n;
      bus.rf_src1 <= wr_n ? idx : '0;
      bus.rf_writeData <= state_n == WRITE ? data_n : '0;
      busy <= state_n != IDLE;
      done <= state_n == DONE;
      error <= (state == IDLE && start) ? 1'b0 : error | abort;
    end
  end
  assign core_stall = busy;
  assign bus.rf_dest = 1'b0;
endmodule

// File: tb/tb_rf_init_sequencer.sv
// tb_rf_init_sequencer: directed load/clear/wait/timeout/reset scenarios with hand-computed expectations
module tb_rf_init_sequencer;
  logic clock = 0, reset_n = 0, start = 0;
  logic [6:0] start_address = '0;
  logic core_stall, busy, done, error;
  rf_init_sequencer_if #(.DATA_W(8), .MADDR_W(8), .IW(3)) bus();
  rf_init_sequencer dut(
    .clock(clock), .reset_n(reset_n), .start(start), .start_address(start_address),
    .bus(bus), .core_stall(core_stall), .busy(busy), .done(done), .error(error)
  );
  always #5 clock = ~clock;
  logic [7:0] mem [256];
  logic [7:0] rf [8];
  int n_chk = 0, n_pass = 0;
  int cyc = 0, t0 = 0;
  int lat = 0, serve_max = 0, served = 0, wcnt = 0;
  bit inject = 0;
  int wr_i[$], wr_d[$], wr_e[$], ad[$];
  int n_done = 0, done_e = -1;
  logic err_d = 0, prev_req = 0;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) if (bus.rf_write === 1'b1) rf[bus.rf_src1] = bus.rf_writeData;
  always @(posedge clock) begin
    #1;
    bus.mem_valid = 1'b0;
    bus.mem_rdata = 8'h00;
    if (bus.mem_req === 1'b1) begin
      if (wcnt == lat && served < serve_max) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = mem[bus.mem_addr];
        served++;
      end
      wcnt++;
    end else begin
      wcnt = 0;
      if (inject && bus.rf_write === 1'b1) begin
        bus.mem_valid = 1'b1;
        bus.mem_rdata = 8'hEE;
      end
    end
  end
  always @(posedge clock) begin
    #1;
    if (bus.rf_write === 1'b1) begin
      wr_i.push_back(int'(bus.rf_src1));
      wr_d.push_back(int'(bus.rf_writeData));
      wr_e.push_back(cyc - t0);
    end
    if (bus.mem_req === 1'b1 && !prev_req) ad.push_back(int'(bus.mem_addr));
    if (done === 1'b1) begin
      n_done++;
      done_e = cyc - t0;
      err_d = error;
    end
    prev_req = bus.mem_req === 1'b1;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask
  function automatic int qat(input int q[$], input int i);
    return i < q.size() ? q[i] : -1;
  endfunction
  function automatic logic [31:0] outs();
    return {6'd0, bus.mem_req, bus.mem_addr, bus.rf_write, bus.rf_dest, bus.rf_src1, bus.rf_writeData,
            core_stall, busy, done, error};
  endfunction
  task automatic kick(input logic [6:0] a, input int l, input int smax, input bit inj);
    @(negedge clock);
    lat = l;
    serve_max = smax;
    inject = inj;
    served = 0;
    wr_i.delete(); wr_d.delete(); wr_e.delete(); ad.delete();
    n_done = 0;
    done_e = -1;
    start = 1;
    start_address = a;
    t0 = cyc + 1;
    @(posedge clock);
    #2;
    start = 0;
    chk("busy_stall_e0", {30'd0, busy, core_stall}, 32'd3);
  endtask
  task automatic wait_done();
    for (int i = 0; i < 100 && n_done == 0; i++) @(posedge clock);
    repeat (3) @(posedge clock);
    #2;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    for (int i = 0; i < 8; i++) begin
      mem[8'h10 + i] = 8'hA0 + 8'(i);
      mem[8'(8'h7E + i)] = 8'h30 + 8'(i);
      mem[8'h20 + i] = 8'h50 + 8'(i);
      rf[i] = 8'hFF;
    end
    repeat (3) @(posedge clock);
    #1;
    chk("reset_outs", outs(), 32'd0);
    @(negedge clock) reset_n = 1;
    // load, zero-wait memory
    kick(7'h10, 0, 99, 0);
    wait_done();
    chk("t1_nwr", wr_i.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1_idx%0d", i), qat(wr_i, i), i);
      chk($sformatf("t1_dat%0d", i), qat(wr_d, i), 32'hA0 + i);
      chk($sformatf("t1_wedge%0d", i), qat(wr_e, i), 2 * i + 1);
      chk($sformatf("t1_addr%0d", i), qat(ad, i), 32'h10 + i);
      chk($sformatf("t1_rf%0d", i), rf[i], 32'hA0 + i);
    end
    chk("t1_done_edge", done_e, 16);
    chk("t1_ndone", n_done, 1);
    chk("t1_err", err_d, 0);
    chk("t1_busy_after", busy, 0);
    // clear mode
    kick(7'h7F, 0, 99, 0);
    wait_done();
    chk("t2_nreq", ad.size(), 0);
    chk("t2_nwr", wr_i.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t2_idx%0d", i), qat(wr_i, i), i);
      chk($sformatf("t2_dat%0d", i), qat(wr_d, i), 0);
      chk($sformatf("t2_wedge%0d", i), qat(wr_e, i), i + 1);
      chk($sformatf("t2_rf%0d", i), rf[i], 0);
    end
    chk("t2_done_edge", done_e, 9);
    // 3-cycle latency, address wrap past 0x7F, stray strobes during WRITE
    kick(7'h7E, 3, 99, 1);
    wait_done();
    chk("t3_nwr", wr_i.size(), 8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t3_addr%0d", i), qat(ad, i), (32'h7E + i) & 32'hFF);
      chk($sformatf("t3_idx%0d", i), qat(wr_i, i), i);
      chk($sformatf("t3_dat%0d", i), qat(wr_d, i), 32'h30 + i);
      chk($sformatf("t3_wedge%0d", i), qat(wr_e, i), 5 * i + 4);
    end
    chk("t3_done_edge", done_e, 40);
    // memory stops answering at the third fetch
    kick(7'h20, 0, 2, 0);
    wait_done();
    chk("t4_nwr", wr_i.size(), 2);
    chk("t4_rf0", rf[0], 32'h50);
    chk("t4_rf1", rf[1], 32'h51);
    chk("t4_rf2_kept", rf[2], 32'h32);
    chk("t4_nreq", ad.size(), 3);
    chk("t4_done_edge", done_e, 19);
    chk("t4_err_at_done", err_d, 1);
    chk("t4_err_sticky", error, 1);
    // start while busy is ignored, then reset in the 4th WRITE
    kick(7'h10, 0, 99, 0);
    chk("t5_err_cleared", error, 0);
    repeat (3) @(negedge clock);
    start = 1;
    start_address = 7'h7F;
    @(negedge clock);
    start = 0;
    repeat (4) @(negedge clock);
    reset_n = 0;
    @(posedge clock);
    #1;
    chk("t5_reset_outs", outs(), 32'd0);
    @(negedge clock) reset_n = 1;
    repeat (20) @(posedge clock);
    #2;
    chk("t5_ndone", n_done, 0);
    chk("t5_nwr", wr_i.size(), 4);
    chk("t5_last_idx", qat(wr_i, 3), 3);
    chk("t5_nreq", ad.size(), 4);
    chk("t5_addr3", qat(ad, 3), 32'h13);
    chk("t5_rf3", rf[3], 32'hA3);
    chk("t5_rf4_kept", rf[4], 32'h34);
    kick(7'h10, 0, 99, 0);
    wait_done();
    chk("t5_restart_idx0", qat(wr_i, 0), 0);
    chk("t5_restart_nwr", wr_i.size(), 8);
    chk("t5_restart_done", done_e, 16);
    chk("t5_restart_rf7", rf[7], 32'hA7);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rf_init_sequencer.md
# rf_init_sequencer

Controller that preloads the 8×8-bit register file before the core runs. On a `start` pulse it either copies an 8-byte register image from data memory into r0..r7 or clears all registers to zero. While it runs it owns the register file write port and holds the core in stall. It sits between the top-level start logic, the data memory read port and the register file write port (`write`/`dest`/`src1`/`writeData`).

## Interface
- `NUM_REGS`, 8: registers to initialise; must equal the register file depth.
- `DATA_W`, 8: register and memory data width.
- `MADDR_W`, 8: data memory address width.
- `TIMEOUT`, 15: maximum FETCH cycles allowed without `mem_valid` before abort.
- `CLEAR_CODE`, 7'h7F: `start_address` value that selects clear mode.

Ports:
- `clock` in 1: single clock; all state updates on posedge.
- `reset_n` in 1: synchronous, active-low reset.
- `start` in 1: request pulse; sampled only in IDLE.
- `start_address` in 7: base address of the image in data memory, or `CLEAR_CODE`.
- `mem_req` out 1: read request to data memory.
- `mem_addr` out `MADDR_W`: read address.
- `mem_rdata` in `DATA_W`: read data, valid when `mem_valid`=1.
- `mem_valid` in 1: read data strobe.
- `rf_write` out 1: register file write enable.
- `rf_dest` out 1: constant 0, so the register file writes to the `src1` index.
- `rf_src1` out 3: destination register index.
- `rf_writeData` out `DATA_W`: write data.
- `core_stall` out 1: holds the core while the sequencer owns the register file.
- `busy` out 1: sequence in progress.
- `done` out 1: one-cycle completion pulse.
- `error` out 1: sticky memory-timeout flag; cleared by the next accepted `start` or by reset.

## Operation
- States: IDLE, FETCH, WRITE, CLEAR, DONE. Internal registers:
  - `idx`: 3 bits.
  - `base`: 7 bits.
  - `data_q`: `DATA_W` bits.
  - `tmo`: 4-bit counter.
- **IDLE**
  - `start`=1 latches `base`, sets `idx`=0, clears `error` and sets `busy` and `core_stall`.
  - If `start_address`==`CLEAR_CODE`, next state is CLEAR; otherwise next state is FETCH.
- **FETCH**
  - Drives `mem_req`=1 and `mem_addr`=({1'b0,`base`}+`idx`) mod 2^`MADDR_W`.
  - `mem_valid`=1 captures `mem_rdata` into `data_q` and moves to WRITE; `tmo` resets.
  - Otherwise `tmo` increments. When `tmo` reaches `TIMEOUT`, `error` is set and the state moves to DONE, leaving the remaining registers unwritten.
- **WRITE** (exactly one cycle)
  - Drives `rf_write`=1, `rf_src1`=`idx`, `rf_writeData`=`data_q`.
  - If `idx`==7, next state is DONE; otherwise `idx`+1 and return to FETCH.
- **CLEAR**
  - Drives `rf_write`=1, `rf_src1`=`idx`, `rf_writeData`=0 every cycle, incrementing `idx`.
  - After the write with `idx`==7, next state is DONE.
  - `mem_req` stays 0 throughout.
- **DONE**
  - `done`=1 for one cycle; `busy` and `core_stall` drop on the same edge.
  - Next state is IDLE.
- `mem_valid` is ignored outside FETCH; an extra strobe arriving in WRITE is dropped.
- `start` is ignored in every state except IDLE. There is no queuing.
- `idx` wraps 7→0 only through a new `start`.
- `rf_dest` is tied to 0 in all states.

## Timing
- All outputs are registered from posedge state. The register file samples them on the following negedge, so the write data is stable for half a cycle.
- Reset values while `reset_n`=0:
  - `mem_req`, `rf_write`, `core_stall`, `busy`, `done` and `error` are all 0.
  - `mem_addr`, `rf_src1` and `rf_writeData` are 0.
  - State is IDLE.
- Reset mid-sequence: all outputs return to reset values on that edge. No `done` pulse is produced, and registers already written keep their values.
- `start` sampled at edge 0 means `busy` and `core_stall` are 1 from edge 0.
- Zero-wait memory (`mem_valid` in the first FETCH cycle):
  - Load mode takes 2 cycles per register.
  - `done` is high from edge 16 to edge 17; `busy` is 0 after edge 17.
- Clear mode: writes occupy edges 1..8 and `done` is high from edge 9.
- Each memory wait cycle adds 1 cycle.
- Timeout: the 15th consecutive FETCH cycle without `mem_valid` sets `error` and enters DONE on the next edge.

## Test plan
1. **Load, zero-wait.** Memory[0x10..0x17]=0xA0..0xA7, `start_address`=0x10, `mem_valid` in the same cycle as each `mem_req`.
   - `mem_addr` steps 0x10..0x17.
   - Eight `rf_write` pulses with `rf_src1` 0..7 and data 0xA0..0xA7.
   - `done` is high exactly at edge 16, `error`=0.
2. **Clear mode.** `start_address`=0x7F.
   - `mem_req` never asserts.
   - `rf_write` is high for 8 consecutive cycles with data 0x00 and `rf_src1` 0..7.
   - `done` is high at edge 9.
3. **Wait states and wrap.** `start_address`=0x7E, 3-cycle memory latency.
   - `mem_addr` steps 0x7E..0x85.
   - `done` is high at edge 40.
   - `mem_valid` pulses injected during WRITE cause no extra writes.
4. **Timeout.** `mem_valid` is held low at the 3rd fetch.
   - r0 and r1 are written.
   - `error`=1 after 15 FETCH cycles, followed by a `done` pulse with no further `rf_write`.
   - The next `start` clears `error`.
5. **Reset and `start` while busy.** Pulse `start` again in the middle of a load; it is ignored. Then assert `reset_n`=0 for 1 cycle in the 4th WRITE.
   - All outputs are 0 after that edge, with no `done` pulse.
   - A subsequent `start` restarts at `idx`=0.
